instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode_pkg.sv | 28 ++
 rtl/instr_decoder.sv | 51 +++++
 rtl/instr_fetch_decode.sv | 113 +++++++++++
 tb/tb_instr_fetch_decode.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: opcode constants,
// fetch FSM state encoding and the reset NOP word.
package instr_fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Opcodes whose immediate lives in [31:20] rather than the split S-format.
  function automatic logic has_i_imm(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational field extraction and enable generation for one
// 32-bit instruction word; enables are suppressed when nothing is issuing.
module instr_decoder
  import instr_fetch_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [11:0] imm_o,
  output logic [4:0]  shamt_o,
  output logic        write_en_o,
  output logic        read_en_o,
  output logic        store_en_o,
  output logic        illegal_o
);

  assign opcode_o = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign funct3_o = instr_i[14:12];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign shamt_o  = instr_i[24:20];
  assign funct7_o = instr_i[31:25];
  assign imm_o    = has_i_imm(instr_i[6:0]) ? instr_i[31:20]
                                            : {instr_i[31:25], instr_i[11:7]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    write_en_o = 1'b0;
    read_en_o  = 1'b0;
    store_en_o = 1'b0;
    illegal_o  = 1'b0;
    if (valid_i) begin
      unique case (instr_i[6:0])
        OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: write_en_o = 1'b1;
        OP_LOAD: begin
          write_en_o = 1'b1;
          read_en_o  = 1'b1;
        end
        OP_STORE: store_en_o = 1'b1;
        default:  illegal_o  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Single-outstanding instruction fetch FSM with PC/redirect handling; the
// latched instruction is decoded by instr_decoder.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = WIDTH'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [6:0]       opcode,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [4:0]       RD,
  output logic [11:0]      Imm_reg,
  output logic [4:0]       Shamt,
  output logic             write_en,
  output logic             read_en,
  output logic             store_en,
  output logic             instr_valid,
  output logic             illegal_instr,
  output logic             misalign_err
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             misalign_q, misalign_d;
  logic             capture, issue_fire;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT:  if (imem_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (!stall) state_d = ST_REQ;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == ST_REQ);
    instr_valid = (state_q == ST_ISSUE);
    capture     = (state_q == ST_WAIT) && imem_valid;
    issue_fire  = (state_q == ST_ISSUE) && !stall;
  end

  // Misaligned redirects are word-aligned by dropping the low bits.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = capture ? imem_rdata : ir_q;
    misalign_d = 1'b0;
    if (issue_fire) begin
      if (branch_taken) begin
        pc_d       = {branch_target[WIDTH-1:2], 2'b00};
        misalign_d = |branch_target[1:0];
      end else begin
        pc_d = pc_q + WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;

  instr_decoder u_decoder (
    .instr_i    (ir_q),
    .valid_i    (instr_valid),
    .opcode_o   (opcode),
    .funct3_o   (Funct3),
    .funct7_o   (Funct7),
    .rs1_o      (RS1),
    .rs2_o      (RS2),
    .rd_o       (RD),
    .imm_o      (Imm_reg),
    .shamt_o    (Shamt),
    .write_en_o (write_en),
    .read_en_o  (read_en),
    .store_en_o (store_en),
    .illegal_o  (illegal_instr)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios plus a
// randomized fetch/stall/branch loop against a behavioural model.
module tb_instr_fetch_decode;

  typedef logic [52:0] dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [6:0]  opcode, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  RS1, RS2, RD, Shamt;
  logic [11:0] Imm_reg;
  logic        write_en, read_en, store_en, instr_valid, illegal_instr, misalign_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_word;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .opcode        (opcode),
    .Funct3        (Funct3),
    .Funct7        (Funct7),
    .RS1           (RS1),
    .RS2           (RS2),
    .RD            (RD),
    .Imm_reg       (Imm_reg),
    .Shamt         (Shamt),
    .write_en      (write_en),
    .read_en       (read_en),
    .store_en      (store_en),
    .instr_valid   (instr_valid),
    .illegal_instr (illegal_instr),
    .misalign_err  (misalign_err)
  );

  function automatic dec_t dut_fields();
    return {opcode, Funct3, Funct7, RS1, RS2, RD, Imm_reg, Shamt,
            write_en, read_en, store_en, illegal_instr};
  endfunction

  // Reference decode from the instruction-set rules, using shifts and masks.
  function automatic dec_t model(input logic [31:0] w, input bit v);
    int unsigned op, rd, f3, rs1, rs2, f7, imm;
    bit wb, ld, st;
    op  = w % 128;
    rd  = (w >> 7) % 32;
    f3  = (w >> 12) % 8;
    rs1 = (w >> 15) % 32;
    rs2 = (w >> 20) % 32;
    f7  = w >> 25;
    imm = (op == 'h13 || op == 'h03 || op == 'h67) ? (w >> 20) : ((f7 << 5) | rd);
    ld  = (op == 'h03);
    st  = (op == 'h23);
    wb  = op inside {'h33, 'h13, 'h03, 'h37, 'h17, 'h6F, 'h67};
    return {7'(op), 3'(f3), 7'(f7), 5'(rs1), 5'(rs2), 5'(rd), 12'(imm), 5'(rs2),
            v && wb, v && ld, v && st, v && !(wb || st)};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    imem_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    last_word = 32'h0000_0013;
  endtask

  // Advance to the request cycle (bounded) and check the fetch address.
  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
    end
    checks++;
    if (imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL imem_addr: got %h required %h", imem_addr, exp_pc);
    end
  endtask

  // From the request cycle: hold off lat cycles in WAIT, then return word.
  task automatic respond(input logic [31:0] word, input int lat);
    imem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, misalign_err} !== 2'b00) begin
      errors++;
      $display("FAIL req_pulse: req,misalign=%b required 00", {imem_req, misalign_err});
    end
    for (int i = 0; i < lat; i++) begin
      checks++;
      if ({instr_valid, dut_fields()} !== {1'b0, model(last_word, 0)}) begin
        errors++;
        $display("FAIL wait_hold: got %h required %h", {instr_valid, dut_fields()},
                 {1'b0, model(last_word, 0)});
      end
      @(negedge clk);
    end
    imem_rdata = word; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = $urandom;
    last_word = word;
    checks++;
    if ({instr_valid, pc, dut_fields()} !== {1'b1, exp_pc, model(word, 1)}) begin
      errors++;
      $display("FAIL issue_decode: got %h required %h", {instr_valid, pc, dut_fields()},
               {1'b1, exp_pc, model(word, 1)});
    end
  endtask

  // Stall nstall cycles (with junk branch/valid inputs), then retire.
  task automatic issue(input int nstall, input bit br, input logic [31:0] tgt);
    logic [1:0] lo;
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1;
      branch_taken = 1'($urandom); branch_target = $urandom;
      imem_valid = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({instr_valid, imem_req, pc, dut_fields()} !== {2'b10, exp_pc, model(last_word, 1)}) begin
        errors++;
        $display("FAIL stall_hold: got %h required %h", {instr_valid, imem_req, pc, dut_fields()},
                 {2'b10, exp_pc, model(last_word, 1)});
      end
    end
    stall = 1'b0; imem_valid = 1'b0;
    branch_taken = br; branch_target = tgt;
    @(negedge clk);
    branch_taken = 1'b0;
    lo = tgt[1:0];
    exp_pc = br ? (tgt & ~32'h3) : exp_pc + 32'd4;
    checks++;
    if ({imem_req, instr_valid, misalign_err, imem_addr, dut_fields()} !==
        {2'b10, br && (lo != 2'b00), exp_pc, model(last_word, 0)}) begin
      errors++;
      $display("FAIL retire: got %h required %h",
               {imem_req, instr_valid, misalign_err, imem_addr, dut_fields()},
               {2'b10, br && (lo != 2'b00), exp_pc, model(last_word, 0)});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, misalign_err, pc, dut_fields()} !==
        {3'b000, 32'h0, model(32'h0000_0013, 0)}) begin
      errors++;
      $display("FAIL reset_state: got %h required %h",
               {imem_req, instr_valid, misalign_err, pc, dut_fields()},
               {3'b000, 32'h0, model(32'h0000_0013, 0)});
    end
    apply_reset();
  endtask

  task automatic test_first_fetch();
    wait_req();
    respond(32'h0050_0093, 0);
    checks++;
    if ({opcode, RD, Imm_reg, write_en} !== {7'h13, 5'd1, 12'd5, 1'b1}) begin
      errors++;
      $display("FAIL first_fetch: got %h required %h", {opcode, RD, Imm_reg, write_en},
               {7'h13, 5'd1, 12'd5, 1'b1});
    end
    issue(0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req();
      respond(32'h0020_8133 + 32'(i << 7), 0);
      issue(0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_stall();
    wait_req();
    respond(32'h4030_5213, 1);
    issue(5, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    wait_req();
    respond(32'h0000_006F, 0);
    issue(0, 1'b1, 32'h100);
    wait_req();
    respond(32'h00A1_2423, 2);
    issue(1, 1'b1, 32'h102);
  endtask

  task automatic test_illegal();
    wait_req();
    respond(32'hFFFF_FFFF, 0);
    checks++;
    if ({illegal_instr, write_en, read_en, store_en} !== 4'b1000) begin
      errors++;
      $display("FAIL illegal: got %b required 1000",
               {illegal_instr, write_en, read_en, store_en});
    end
    issue(2, 1'b0, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    wait_req();
    imem_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pc, instr_valid, imem_req} !== {32'h0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", {pc, instr_valid, imem_req}, {32'h0, 2'b00});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    last_word = 32'h0000_0013;
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wait_req();
    respond(32'h0000_0003, 1);
    issue(0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [31:0] w;
    for (int n = 0; n < 30; n++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(7)];
      wait_req();
      respond(w, $urandom_range(3));
      issue($urandom_range(3), $urandom_range(2) == 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_branch();
    test_illegal();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
